// File: rtl/conv_ctrl_pkg.sv
// Shared constants for the convolution command front-end: opcodes,
// command-word field positions, FSM state encodings and status bit indices.
package conv_ctrl_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 29;
    localparam int TAG_BIT = 28;

    localparam logic [2:0] OP_NOP        = 3'b000;
    localparam logic [2:0] OP_CORE_RST   = 3'b001;
    localparam logic [2:0] OP_SET_LEN    = 3'b010;
    localparam logic [2:0] OP_LOAD_BEGIN = 3'b011;
    localparam logic [2:0] OP_DATA       = 3'b100;
    localparam logic [2:0] OP_LOAD_END   = 3'b101;
    localparam logic [2:0] OP_START      = 3'b110;
    localparam logic [2:0] OP_READ_NEXT  = 3'b111;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOADING  = 3'd1;
    localparam logic [2:0] ST_PROCESS  = 3'd2;
    localparam logic [2:0] ST_WAIT_EOP = 3'd3;
    localparam logic [2:0] ST_READING  = 3'd4;

    localparam int STAT_ACK       = 0;
    localparam int STAT_STATE_LSB = 1;
    localparam int STAT_ERR       = 4;
    localparam int STAT_EOP       = 5;
    localparam int STAT_CB        = 6;

    // Shortest image the sequencing FSM can process (3x3 kernel window).
    localparam int MIN_IMG_LENGTH = 3;

endpackage

// File: rtl/gpio_tag_detect.sv
// Toggle-tag acceptance: a command word is new when its tag differs from the
// last accepted tag; acceptance is held off while the caller blocks it.
module gpio_tag_detect (
    input  logic clk,
    input  logic reset,
    input  logic tag_in,
    input  logic block,
    output logic accept,
    output logic last_tag
);

    assign accept = (tag_in != last_tag) && !block;

    // Remember the tag of the most recently accepted command.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_tag <= 1'b0;
        end else if (accept) begin
            last_tag <= tag_in;
        end
    end

endmodule

// File: rtl/conv_cmd_decoder.sv
// Decodes host GPIO command words into the control levels/strobes of the
// 2D-convolution sequencing FSM and reports status back over GPIO.
module conv_cmd_decoder
    import conv_ctrl_pkg::*;
#(
    parameter int NB_GPIO   = 32,
    parameter int NB_IMAGE  = 10,
    parameter int NB_DATA   = 8,
    parameter int NB_STATES = 3
) (
    input  logic                i_CLK,
    input  logic                i_reset,
    input  logic [NB_GPIO-1:0]  i_gpio_data,
    input  logic                i_EoP,
    input  logic                i_changeBlock,
    output logic                o_load,
    output logic                o_SoP,
    output logic                o_valid,
    output logic [NB_IMAGE-1:0] o_imgLength,
    output logic [NB_DATA-1:0]  o_pixel,
    output logic                o_core_reset,
    output logic [NB_GPIO-1:0]  o_gpio_status
);

    logic [2:0]           opcode;
    logic                 accept;
    logic                 last_tag;
    logic [NB_STATES-1:0] state;
    logic                 error;
    logic                 core_hold;
    logic                 cb_q;
    logic                 cb_rise;
    logic [NB_GPIO-1:0]   status_next;
    logic                 unused_gpio;

    assign opcode      = i_gpio_data[OPC_MSB:OPC_LSB];
    assign cb_rise     = i_changeBlock && !cb_q;
    assign unused_gpio = ^i_gpio_data[TAG_BIT-1:NB_IMAGE];

    gpio_tag_detect u_tag (
        .clk      (i_CLK),
        .reset    (i_reset),
        .tag_in   (i_gpio_data[TAG_BIT]),
        .block    (o_valid),
        .accept   (accept),
        .last_tag (last_tag)
    );

    // Command decode and state sequencing; CORE_RST overrides every state.
    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            o_load       <= 1'b0;
            o_SoP        <= 1'b0;
            o_valid      <= 1'b0;
            o_imgLength  <= '0;
            o_pixel      <= '0;
            o_core_reset <= 1'b0;
            core_hold    <= 1'b0;
            error        <= 1'b0;
            cb_q         <= 1'b0;
        end else begin
            o_valid      <= 1'b0;
            cb_q         <= i_changeBlock;
            core_hold    <= 1'b0;
            o_core_reset <= core_hold;
            if (accept && opcode == OP_CORE_RST) begin
                o_core_reset <= 1'b1;
                core_hold    <= 1'b1;
                o_load       <= 1'b0;
                o_SoP        <= 1'b0;
                o_pixel      <= '0;
                state        <= ST_IDLE;
                error        <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            case (opcode)
                                OP_NOP: ;
                                OP_SET_LEN: o_imgLength <= i_gpio_data[NB_IMAGE-1:0];
                                OP_LOAD_BEGIN: begin
                                    state  <= ST_LOADING;
                                    o_load <= 1'b1;
                                end
                                OP_START: begin
                                    if (o_imgLength >= NB_IMAGE'(MIN_IMG_LENGTH) && !i_EoP) begin
                                        state <= ST_PROCESS;
                                        o_SoP <= 1'b1;
                                    end else begin
                                        error <= 1'b1;
                                    end
                                end
                                OP_READ_NEXT: begin
                                    if (i_EoP) state <= ST_READING;
                                    else       error <= 1'b1;
                                end
                                default: error <= 1'b1;
                            endcase
                        end
                    end
                    ST_LOADING: begin
                        if (accept) begin
                            case (opcode)
                                OP_NOP: ;
                                OP_DATA: begin
                                    o_pixel <= i_gpio_data[NB_DATA-1:0];
                                    o_valid <= 1'b1;
                                end
                                OP_LOAD_END: begin
                                    o_load <= 1'b0;
                                    state  <= ST_IDLE;
                                end
                                default: error <= 1'b1;
                            endcase
                        end
                    end
                    ST_PROCESS: begin
                        if (i_EoP) begin
                            o_SoP <= 1'b0;
                            state <= ST_WAIT_EOP;
                            if (accept) error <= 1'b1;
                        end else if (accept && opcode != OP_NOP) begin
                            error <= 1'b1;
                        end
                    end
                    ST_WAIT_EOP: begin
                        if (!o_SoP) state <= ST_IDLE;
                        if (accept && opcode != OP_NOP) error <= 1'b1;
                    end
                    ST_READING: begin
                        if (accept) begin
                            if (opcode == OP_READ_NEXT) o_valid <= 1'b1;
                            else if (opcode != OP_NOP)  error   <= 1'b1;
                        end
                        if (cb_rise) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Assemble the status word from the current internal registers.
    always_comb begin
        status_next                              = '0;
        status_next[STAT_ACK]                    = last_tag;
        status_next[STAT_STATE_LSB +: NB_STATES] = state;
        status_next[STAT_ERR]                    = error;
        status_next[STAT_EOP]                    = i_EoP;
        status_next[STAT_CB]                     = i_changeBlock;
    end

    // Register the status word so the host sees a clean, glitch-free value.
    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            o_gpio_status <= '0;
        end else begin
            o_gpio_status <= status_next;
        end
    end

endmodule

// File: tb/tb_conv_cmd_decoder.sv
// Directed bench for conv_cmd_decoder: every step drives inputs right after a
// rising edge and checks the registered outputs one step later.
module tb_conv_cmd_decoder;

    localparam logic [2:0] OP_NOP        = 3'b000;
    localparam logic [2:0] OP_CORE_RST   = 3'b001;
    localparam logic [2:0] OP_SET_LEN    = 3'b010;
    localparam logic [2:0] OP_LOAD_BEGIN = 3'b011;
    localparam logic [2:0] OP_DATA       = 3'b100;
    localparam logic [2:0] OP_LOAD_END   = 3'b101;
    localparam logic [2:0] OP_START      = 3'b110;
    localparam logic [2:0] OP_READ_NEXT  = 3'b111;

    logic        clk;
    logic        reset;
    logic [31:0] gpioData;
    logic        eop;
    logic        changeBlock;
    logic        load;
    logic        sop;
    logic        valid;
    logic [9:0]  imgLength;
    logic [7:0]  pixel;
    logic        coreReset;
    logic [31:0] gpioStatus;

    logic        tag;
    int          testsRun;
    int          failCount;

    conv_cmd_decoder dut (
        .i_CLK         (clk),
        .i_reset       (reset),
        .i_gpio_data   (gpioData),
        .i_EoP         (eop),
        .i_changeBlock (changeBlock),
        .o_load        (load),
        .o_SoP         (sop),
        .o_valid       (valid),
        .o_imgLength   (imgLength),
        .o_pixel       (pixel),
        .o_core_reset  (coreReset),
        .o_gpio_status (gpioStatus)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic presentCmd(input logic [2:0] op, input logic [27:0] payload);
        tag      = ~tag;
        gpioData = {op, tag, payload};
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [27:0] payload);
        presentCmd(op, payload);
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    function automatic logic [31:0] expStatus(input logic [2:0] st, input logic err, input logic e, input logic cb);
        return {25'b0, cb, e, err, st, tag};
    endfunction

    // Linear sequence of directed steps.
    initial begin
        logic [7:0] pix;
        logic [7:0] burst [4];
        testsRun    = 0;
        failCount   = 0;
        tag         = 1'b0;
        reset       = 1'b1;
        gpioData    = '0;
        eop         = 1'b0;
        changeBlock = 1'b0;
        tick();
        tick();
        checkOutput("rst_load", load, 0);
        checkOutput("rst_sop", sop, 0);
        checkOutput("rst_valid", valid, 0);
        checkOutput("rst_len", imgLength, 0);
        checkOutput("rst_pixel", pixel, 0);
        checkOutput("rst_core", coreReset, 0);
        checkOutput("rst_status", gpioStatus, 0);
        reset = 1'b0;
        tick();

        applyStimulus(OP_SET_LEN, 28'd100);
        checkOutput("setlen_len", imgLength, 100);
        tick();
        checkOutput("setlen_status", gpioStatus, expStatus(3'd0, 0, 0, 0));

        applyStimulus(OP_LOAD_BEGIN, 28'd0);
        checkOutput("loadbegin_load", load, 1);
        tick();
        checkOutput("loadbegin_status", gpioStatus, expStatus(3'd1, 0, 0, 0));

        for (int i = 0; i < 100; i++) begin
            pix = 8'(i * 7 + 3);
            applyStimulus(OP_DATA, {20'd0, pix});
            checkOutput("data_valid", valid, 1);
            checkOutput("data_pixel", pixel, pix);
            checkOutput("data_load", load, 1);
            tick();
            checkOutput("data_valid_low", valid, 0);
        end

        burst[0] = 8'hA1;
        burst[1] = 8'hB2;
        burst[2] = 8'hC3;
        burst[3] = 8'hD4;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_DATA, {20'd0, burst[i]});
            checkOutput("b2b_valid", valid, 1);
            checkOutput("b2b_pixel", pixel, burst[i]);
            if (i < 3) begin
                presentCmd(OP_DATA, {20'd0, burst[i+1]});
                tick();
                checkOutput("b2b_blocked", valid, 0);
                checkOutput("b2b_hold_pixel", pixel, burst[i]);
                gpioData = gpioData;
            end else begin
                tick();
                checkOutput("b2b_last_low", valid, 0);
            end
            if (i < 3) tag = ~tag;
        end

        applyStimulus(OP_LOAD_END, 28'd0);
        checkOutput("loadend_load", load, 0);
        tick();
        checkOutput("loadend_status", gpioStatus, expStatus(3'd0, 0, 0, 0));

        applyStimulus(OP_START, 28'd0);
        checkOutput("start_sop", sop, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("process_sop", sop, 1);
        end
        checkOutput("process_status", gpioStatus, expStatus(3'd2, 0, 0, 0));
        eop = 1'b1;
        tick();
        checkOutput("eop_sop_low", sop, 0);
        checkOutput("eop_status", gpioStatus, expStatus(3'd2, 0, 1, 0));
        tick();
        checkOutput("waiteop_status", gpioStatus, expStatus(3'd3, 0, 1, 0));
        tick();
        checkOutput("eop_idle_status", gpioStatus, expStatus(3'd0, 0, 1, 0));

        eop = 1'b0;
        tick();
        applyStimulus(OP_SET_LEN, 28'd2);
        checkOutput("short_len", imgLength, 2);
        applyStimulus(OP_START, 28'd0);
        checkOutput("short_start_sop", sop, 0);
        tick();
        checkOutput("short_start_err", gpioStatus, expStatus(3'd0, 1, 0, 0));
        applyStimulus(OP_CORE_RST, 28'd0);
        checkOutput("corerst_c1", coreReset, 1);
        tick();
        checkOutput("corerst_c2", coreReset, 1);
        checkOutput("corerst_status", gpioStatus, expStatus(3'd0, 0, 0, 0));
        tick();
        checkOutput("corerst_c3", coreReset, 0);
        checkOutput("corerst_len_kept", imgLength, 2);

        applyStimulus(OP_READ_NEXT, 28'd0);
        tick();
        checkOutput("readnext_noeop_err", gpioStatus, expStatus(3'd0, 1, 0, 0));
        applyStimulus(OP_CORE_RST, 28'd0);
        tick();
        tick();
        checkOutput("corerst2_done", coreReset, 0);
        checkOutput("corerst2_status", gpioStatus, expStatus(3'd0, 0, 0, 0));

        eop = 1'b1;
        tick();
        applyStimulus(OP_READ_NEXT, 28'd0);
        checkOutput("enter_read_valid", valid, 0);
        tick();
        checkOutput("reading_status", gpioStatus, expStatus(3'd4, 0, 1, 0));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(OP_READ_NEXT, 28'd0);
            checkOutput("read_valid", valid, 1);
            tick();
            checkOutput("read_valid_low", valid, 0);
        end
        changeBlock = 1'b1;
        applyStimulus(OP_READ_NEXT, 28'd0);
        checkOutput("read4_valid", valid, 1);
        tick();
        checkOutput("read4_valid_low", valid, 0);
        checkOutput("cb_idle_status", gpioStatus, expStatus(3'd0, 0, 1, 1));

        applyStimulus(OP_NOP, 28'd0);
        applyStimulus(OP_CORE_RST, 28'd0);
        checkOutput("midrst_core_hi", coreReset, 1);
        reset    = 1'b1;
        gpioData = '0;
        tag      = 1'b0;
        tick();
        checkOutput("midrst_core_lo", coreReset, 0);
        checkOutput("midrst_len", imgLength, 0);
        checkOutput("midrst_status", gpioStatus, 0);
        reset       = 1'b0;
        eop         = 1'b0;
        changeBlock = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
